// File: rtl/traffic_disp_pkg.sv
// Shared constants for the traffic-light countdown display:
// segment codes {g..a} active-low, slot indices, anode-off pattern.
package traffic_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic [1:0] {
    SLOT_T1_ONES = 2'd0,
    SLOT_T1_TENS = 2'd1,
    SLOT_T2_ONES = 2'd2,
    SLOT_T2_TENS = 2'd3
  } slot_e;

  function automatic logic [6:0] seg_of(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin5_to_bcd.sv
// 5-bit binary (0..31) to two BCD digits, combinational.
// Ports: v in 5, tens out 2 (0..3), ones out 4 (0..9).
module bin5_to_bcd (
  input  logic [4:0] v,
  output logic [1:0] tens,
  output logic [3:0] ones
);

  logic [4:0] sub;
  logic [4:0] rem;

  always_comb begin
    tens = 2'd0;
    sub  = 5'd0;
    if (v >= 5'd30) begin
      tens = 2'd3;
      sub  = 5'd30;
    end else if (v >= 5'd20) begin
      tens = 2'd2;
      sub  = 5'd20;
    end else if (v >= 5'd10) begin
      tens = 2'd1;
      sub  = 5'd10;
    end
  end

  assign rem  = v - sub;
  assign ones = rem[3:0];

endmodule

// File: rtl/countdown_display_scan.sv
// 4-digit multiplexed display of the two road countdowns, with
// yellow-lamp blink. Ports: CLK, RET(async high), T1/T2 (5b),
// MY/CY, SEG (7b, active-low), DP (active-low, off), AN (4b).
module countdown_display_scan
  import traffic_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYC     = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       CLK,
  input  logic       RET,
  input  logic [4:0] T1,
  input  logic [4:0] T2,
  input  logic       MY,
  input  logic       CY,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [3:0] AN
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    slot, slot_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic          phase_on, phase_n;
  logic          first;
  logic [4:0]    sh_t1, sh_t2, t1_n, t2_n;
  logic          sh_my, sh_cy, my_n, cy_n;

  logic tick, frame_end, cap, fwrap, blink;
  logic [1:0] t1_tens, t2_tens;
  logic [3:0] t1_ones, t2_ones;
  logic [6:0] dig_seg;
  logic [3:0] an_n;

  assign tick      = (cnt == CW'(SCAN_DIV - 1));
  assign frame_end = tick && (slot == 2'd3);
  // first tick after reset also loads the shadows
  assign cap       = tick && (frame_end || first);
  assign fwrap     =
    frame_end && (fcnt == FW'(BLINK_FRAMES - 1));

  assign cnt_n  = tick ? '0 : cnt + 1'b1;
  assign slot_n = tick ? slot + 2'd1 : slot;
  assign fcnt_n = frame_end
                ? (fwrap ? '0 : fcnt + 1'b1)
                : fcnt;
  assign phase_n = fwrap ? ~phase_on : phase_on;

  assign t1_n = cap ? T1 : sh_t1;
  assign t2_n = cap ? T2 : sh_t2;
  assign my_n = cap ? MY : sh_my;
  assign cy_n = cap ? CY : sh_cy;

  // decode from next-state values so the new frame sees
  // the fresh shadows and phase together
  bin5_to_bcd u_bcd1 (
    .v    (t1_n),
    .tens (t1_tens),
    .ones (t1_ones)
  );

  bin5_to_bcd u_bcd2 (
    .v    (t2_n),
    .tens (t2_tens),
    .ones (t2_ones)
  );

  assign blink = ~phase_n & (slot_n[1] ? cy_n : my_n);

  always_comb begin
    dig_seg = SEG_BLANK;
    unique case (slot_e'(slot_n))
      SLOT_T1_ONES: dig_seg = seg_of(t1_ones);
      SLOT_T1_TENS: dig_seg = (t1_tens == 2'd0)
                            ? SEG_BLANK
                            : seg_of({2'b00, t1_tens});
      SLOT_T2_ONES: dig_seg = seg_of(t2_ones);
      SLOT_T2_TENS: dig_seg = (t2_tens == 2'd0)
                            ? SEG_BLANK
                            : seg_of({2'b00, t2_tens});
      default:      dig_seg = SEG_BLANK;
    endcase
    if (blink) dig_seg = SEG_BLANK;
  end

  always_comb begin
    an_n = AN_OFF;
    if (cnt_n >= CW'(DEAD_CYC))
      an_n = ~(4'b0001 << slot_n);
  end

  always_ff @(posedge CLK or posedge RET) begin
    if (RET) begin
      cnt      <= '0;
      slot     <= 2'd0;
      fcnt     <= '0;
      phase_on <= 1'b1;
      first    <= 1'b1;
      sh_t1    <= 5'd0;
      sh_t2    <= 5'd0;
      sh_my    <= 1'b0;
      sh_cy    <= 1'b0;
      SEG      <= SEG_BLANK;
      DP       <= 1'b1;
      AN       <= AN_OFF;
    end else begin
      cnt      <= cnt_n;
      slot     <= slot_n;
      fcnt     <= fcnt_n;
      phase_on <= phase_n;
      first    <= first & ~tick;
      sh_t1    <= t1_n;
      sh_t2    <= t2_n;
      sh_my    <= my_n;
      sh_cy    <= cy_n;
      DP       <= 1'b1;
      AN       <= an_n;
      if (tick) SEG <= dig_seg;
    end
  end

endmodule

// File: tb/tb_countdown_display_scan.sv
// Bench for countdown_display_scan: table vectors, hand-built
// tear/blink sequences and a randomized run against a model.
module tb_countdown_display_scan;

  localparam int D    = 4;
  localparam int DC   = 1;
  localparam int BF   = 2;
  localparam int NMAX = 4096;

  logic       CLK = 1'b0;
  logic       RET = 1'b1;
  logic [4:0] T1 = 5'd0;
  logic [4:0] T2 = 5'd0;
  logic       MY = 1'b0;
  logic       CY = 1'b0;
  logic [6:0] SEG;
  logic       DP;
  logic [3:0] AN;

  always #5 CLK = ~CLK;

  countdown_display_scan #(
    .SCAN_DIV     (D),
    .DEAD_CYC     (DC),
    .BLINK_FRAMES (BF)
  ) dut (
    .CLK (CLK),
    .RET (RET),
    .T1  (T1),
    .T2  (T2),
    .MY  (MY),
    .CY  (CY),
    .SEG (SEG),
    .DP  (DP),
    .AN  (AN)
  );

  int passed = 0;
  int total  = 0;
  int n      = 0;

  int h_t1 [NMAX];
  int h_t2 [NMAX];
  bit h_my [NMAX];
  bit h_cy [NMAX];

  logic [6:0] segtab [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef struct {
    int t1;
    int t2;
    logic [3:0][6:0] s;
  } vec_t;

  vec_t tab [5];

  task automatic chk(string nm, logic [11:0] act,
                     logic [11:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s n=%0d got %h want %h",
                  nm, n, act, exp);
  endtask

  // outputs seen during cycle n after reset release
  function automatic logic [3:0] model_an(int c);
    logic [3:0] a;
    if (c % D < DC) return 4'hF;
    a = 4'b0001 << ((c / D) % 4);
    return ~a;
  endfunction

  function automatic logic [6:0] model_seg(int c);
    int k, slot, p, idx, v, f, d;
    bit y, off;
    k = c / D;
    if (k == 0) return 7'h7F;
    slot = k % 4;
    p    = (k < 4) ? 1 : (k / 4) * 4;
    idx  = p * D - 1;
    v    = (slot < 2) ? h_t1[idx] : h_t2[idx];
    y    = (slot < 2) ? h_my[idx] : h_cy[idx];
    f    = k / 4;
    off  = ((f / BF) % 2) == 1;
    if (y && off) return 7'h7F;
    if (slot % 2 == 1) begin
      d = v / 10;
      if (d == 0) return 7'h7F;
    end else begin
      d = v % 10;
    end
    return segtab[d];
  endfunction

  task automatic step();
    h_t1[n] = int'(T1);
    h_t2[n] = int'(T2);
    h_my[n] = MY;
    h_cy[n] = CY;
    @(negedge CLK);
    n++;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 RET = 1'b1;
    #1;
    chk("rst_out", {AN, SEG, DP}, {4'hF, 7'h7F, 1'b1});
    @(negedge CLK);
    @(negedge CLK);
    RET = 1'b0;
    n = 0;
  endtask

  task automatic set_vec(int i, int a, int b,
                         logic [6:0] s0, logic [6:0] s1,
                         logic [6:0] s2, logic [6:0] s3);
    tab[i].t1   = a;
    tab[i].t2   = b;
    tab[i].s[0] = s0;
    tab[i].s[1] = s1;
    tab[i].s[2] = s2;
    tab[i].s[3] = s3;
  endtask

  logic [3:0] an_exp;
  logic [6:0] sexp;

  initial begin
    set_vec(0, 25, 30, 7'h12, 7'h24, 7'h40, 7'h30);
    set_vec(1,  7, 31, 7'h78, 7'h7F, 7'h79, 7'h30);
    set_vec(2, 31,  0, 7'h79, 7'h30, 7'h40, 7'h7F);
    set_vec(3, 10,  9, 7'h40, 7'h79, 7'h10, 7'h7F);
    set_vec(4, 19, 20, 7'h10, 7'h79, 7'h40, 7'h24);

    repeat (3) @(negedge CLK);

    // steady-state frames from the table
    for (int i = 0; i < 5; i++) begin
      do_reset();
      T1 = 5'(tab[i].t1);
      T2 = 5'(tab[i].t2);
      MY = 1'b0;
      CY = 1'b0;
      while (n < 8 * D) begin
        if (n / D >= 4 && n % D == 0)
          chk("dead", {8'h0, AN}, {8'h0, 4'hF});
        if (n / D >= 4 && n % D == D - 1) begin
          an_exp = 4'b0001 << ((n / D) % 4);
          an_exp = ~an_exp;
          chk("table", {1'b0, AN, SEG},
              {1'b0, an_exp, tab[i].s[(n / D) % 4]});
        end
        step();
      end
    end

    // mid-frame change must not tear the frame
    do_reset();
    T1 = 5'd25;
    T2 = 5'd30;
    while (n < 10 * D) begin
      if (n == 6 * D) T1 = 5'd24;
      if (n % D == D - 1) begin
        if (n / D == 6) chk("tear_s2", {5'h0, SEG}, 12'h040);
        if (n / D == 7) chk("tear_s3", {5'h0, SEG}, 12'h030);
        if (n / D == 8) chk("new_s0", {5'h0, SEG}, 12'h019);
        if (n / D == 9) chk("new_s1", {5'h0, SEG}, 12'h024);
      end
      step();
    end

    // blink: 2 frames on, 2 off; yellow drop shows at once
    do_reset();
    T1 = 5'd4;
    T2 = 5'd30;
    MY = 1'b1;
    CY = 1'b0;
    while (n < 32 * D) begin
      if (n == 25 * D) MY = 1'b0;
      if (n % D == D - 1 && n / D >= 4) begin
        if ((n / D) % 4 == 0) begin
          if (n / D >= 28) sexp = 7'h19;
          else if (((n / D / 4) % 4) < 2) sexp = 7'h19;
          else sexp = 7'h7F;
          chk("blink_t1", {5'h0, SEG}, {5'h0, sexp});
        end
        if ((n / D) % 4 == 2)
          chk("steady_t2", {5'h0, SEG}, 12'h040);
      end
      step();
    end

    // randomized run against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      chk("model", {AN, SEG, DP},
          {model_an(n), model_seg(n), 1'b1});
      if ($urandom_range(7) == 0) T1 = 5'($urandom_range(31));
      if ($urandom_range(7) == 0) T2 = 5'($urandom_range(31));
      if ($urandom_range(40) == 0) MY = ~MY;
      if ($urandom_range(40) == 0) CY = ~CY;
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
